filter_sweep_scheduler: RTL and testbench

FILTER_SWEEP_SCHEDULER -- requirements
Module: filter_sweep_scheduler

---
 rtl/filter_sweep_scheduler.sv | 122 ++++++++++++
 tb/tb_filter_sweep_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/filter_sweep_scheduler.sv
// filter_sweep_scheduler: replays the capture buffer once per sweep into two matched filters,
// tracks each filter's maximum score and reports the winner after the final sweep.
module filter_sweep_scheduler #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int MATCH_SCORE_WIDTH = 32,
    parameter int CAPTURE_LENGTH    = 1000,
    parameter int NUM_SWEEPS        = 2001
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    output logic [$clog2(CAPTURE_LENGTH)-1:0]   ram_read_addr,
    input  logic [SAMPLE_DATA_WIDTH-1:0]        ram_read_data,
    output logic                                filter_axiiv,
    output logic [SAMPLE_DATA_WIDTH-1:0]        filter_axiid,
    input  logic                                score1_valid,
    input  logic [MATCH_SCORE_WIDTH-1:0]        score1,
    input  logic                                score2_valid,
    input  logic [MATCH_SCORE_WIDTH-1:0]        score2,
    output logic                                result_valid,
    output logic                                result_id,
    output logic [MATCH_SCORE_WIDTH-1:0]        result_score,
    output logic                                busy
);
    localparam int AW = $clog2(CAPTURE_LENGTH);
    localparam int CW = $clog2(NUM_SWEEPS + 1);
    localparam logic [AW-1:0] LAST = AW'(CAPTURE_LENGTH - 1);
    localparam logic [CW-1:0] NS = CW'(NUM_SWEEPS);

    typedef enum logic [2:0] {IDLE, SWEEP, GAP, DRAIN, DECIDE} state_t;
    state_t state;

    logic [CW-1:0] sweeps, cnt1, cnt2, n1, n2;
    logic [MATCH_SCORE_WIDTH-1:0] max1, max2, m1, m2;
    logic [1:0] gap;
    logic d1, d2, acc1, acc2;

    // next-cycle counter and maximum values, so DRAIN can decide on a score arriving this cycle
    always_comb begin
        acc1 = (state != IDLE) && score1_valid && (cnt1 != NS);
        acc2 = (state != IDLE) && score2_valid && (cnt2 != NS);
        n1 = cnt1 + CW'(acc1);
        n2 = cnt2 + CW'(acc2);
        m1 = (acc1 && (cnt1 == '0 || $signed(score1) > $signed(max1))) ? score1 : max1;
        m2 = (acc2 && (cnt2 == '0 || $signed(score2) > $signed(max2))) ? score2 : max2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sweeps        <= '0;
            cnt1          <= '0;
            cnt2          <= '0;
            max1          <= '0;
            max2          <= '0;
            gap           <= '0;
            d1            <= 1'b0;
            d2            <= 1'b0;
            ram_read_addr <= '0;
            filter_axiiv  <= 1'b0;
            filter_axiid  <= '0;
            result_valid  <= 1'b0;
            result_id     <= 1'b0;
            result_score  <= '0;
            busy          <= 1'b0;
        end else begin
            d1           <= state == SWEEP;
            d2           <= d1;
            filter_axiiv <= d2;
            if (d2) filter_axiid <= ram_read_data;
            cnt1         <= n1;
            cnt2         <= n2;
            max1         <= m1;
            max2         <= m2;
            result_valid <= 1'b0;
            if (state != IDLE && abort) begin
                state         <= IDLE;
                busy          <= 1'b0;
                ram_read_addr <= '0;
                d1            <= 1'b0;
                d2            <= 1'b0;
                filter_axiiv  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state         <= SWEEP;
                        busy          <= 1'b1;
                        sweeps        <= '0;
                        cnt1          <= '0;
                        cnt2          <= '0;
                        max1          <= '0;
                        max2          <= '0;
                        ram_read_addr <= '0;
                    end
                    SWEEP: begin
                        ram_read_addr <= (ram_read_addr == LAST) ? '0 : ram_read_addr + AW'(1);
                        gap           <= '0;
                        if (ram_read_addr == LAST) state <= GAP;
                    end
                    GAP: begin
                        gap <= gap + 2'd1;
                        if (gap == 2'd2) begin
                            sweeps <= sweeps + CW'(1);
                            state  <= (sweeps + CW'(1) < NS) ? SWEEP : DRAIN;
                        end
                    end
                    DRAIN: if (n1 == NS && n2 == NS) begin
                        state        <= DECIDE;
                        result_valid <= 1'b1;
                        result_id    <= $signed(m2) > $signed(m1);
                        result_score <= ($signed(m2) > $signed(m1)) ? m2 : m1;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_filter_sweep_scheduler.sv
// tb_filter_sweep_scheduler: directed and randomized runs checked against a cycle-timeline model.
module tb_filter_sweep_scheduler;
    localparam int CL = 4;
    localparam int NS = 3;
    localparam int P  = CL + 3;

    logic clk = 1'b0;
    logic rst, start, abort, score1_valid, score2_valid;
    logic filter_axiiv, result_valid, result_id, busy;
    logic [1:0] ram_read_addr;
    logic [7:0] ram_read_data, filter_axiid, r1;
    logic [31:0] score1, score2, result_score;
    logic [7:0] mem [0:CL-1];

    int checks = 0;
    int errors = 0;
    bit sv1 [0:63], sv2 [0:63], st [0:63], ab [0:63], rs [0:63];
    int sd1 [0:63], sd2 [0:63];
    logic prev_id = 1'b0;
    logic [31:0] prev_sc = '0;

    filter_sweep_scheduler #(
        .SAMPLE_DATA_WIDTH(8), .MATCH_SCORE_WIDTH(32), .CAPTURE_LENGTH(CL), .NUM_SWEEPS(NS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
        .filter_axiiv(filter_axiiv), .filter_axiid(filter_axiid),
        .score1_valid(score1_valid), .score1(score1),
        .score2_valid(score2_valid), .score2(score2),
        .result_valid(result_valid), .result_id(result_id),
        .result_score(result_score), .busy(busy)
    );

    always #5 clk = ~clk;

    // capture buffer with two cycles of read latency
    always @(posedge clk) begin
        r1            <= mem[ram_read_addr];
        ram_read_data <= r1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        for (int c = 0; c < 64; c++) begin
            sv1[c] = 0; sv2[c] = 0; st[c] = 0; ab[c] = 0; rs[c] = 0; sd1[c] = 0; sd2[c] = 0;
        end
    endtask

    // Start a run in the current cycle (cycle 0) and check 63 following cycles.
    task automatic run(input string name);
        int cnt1, cnt2, m1, m2, l1, l2, rc, stp, fin, k, s;
        int d;
        bit got, rstd, ev;
        logic eid, xid;
        logic [31:0] esc, xsc;
        cnt1 = 0; cnt2 = 0; m1 = 0; m2 = 0; l1 = 0; l2 = 0; stp = 1000; rstd = 0;
        d = 1 + NS * P;
        for (int c = 1; c < 64; c++) begin
            if (sv1[c] && cnt1 < NS) begin
                m1 = (cnt1 == 0 || sd1[c] > m1) ? sd1[c] : m1;
                cnt1++;
                if (cnt1 == NS) l1 = c;
            end
            if (sv2[c] && cnt2 < NS) begin
                m2 = (cnt2 == 0 || sd2[c] > m2) ? sd2[c] : m2;
                cnt2++;
                if (cnt2 == NS) l2 = c;
            end
        end
        rc = d;
        if (l1 > rc) rc = l1;
        if (l2 > rc) rc = l2;
        rc = (l1 == 0 || l2 == 0) ? 1000 : rc + 1;
        for (int c = 1; c <= rc && c < 64; c++)
            if ((ab[c] || rs[c]) && stp == 1000) stp = c;
        if (stp < 64) rstd = rs[stp];
        got = stp >= rc;
        fin = got ? rc + 1 : stp + 1;
        eid = m2 > m1;
        esc = eid ? m2 : m1;
        start = 1'b1;
        for (int c = 1; c < 64; c++) begin
            tick();
            start = st[c]; abort = ab[c]; rst = rs[c];
            score1_valid = sv1[c]; score1 = sd1[c];
            score2_valid = sv2[c]; score2 = sd2[c];
            k = (c - 4) % P;
            s = (c - 4) / P;
            ev = c < fin && c >= 4 && k < CL && s < NS;
            xid = (rstd && c > stp) ? 1'b0 : (got && c >= rc) ? eid : prev_id;
            xsc = (rstd && c > stp) ? '0 : (got && c >= rc) ? esc : prev_sc;
            chk($sformatf("%s busy c%0d", name, c), busy, c < fin);
            chk($sformatf("%s axiiv c%0d", name, c), filter_axiiv, ev);
            if (ev) chk($sformatf("%s axiid c%0d", name, c), filter_axiid, mem[k]);
            chk($sformatf("%s result_valid c%0d", name, c), result_valid, got && c == rc);
            chk($sformatf("%s result_id c%0d", name, c), result_id, xid);
            chk($sformatf("%s result_score c%0d", name, c), result_score, xsc);
            if (rstd && c == stp + 1) begin
                chk($sformatf("%s rst addr", name), ram_read_addr, 0);
                chk($sformatf("%s rst axiid", name), filter_axiid, 0);
            end
        end
        if (rstd) begin
            prev_id = 1'b0;
            prev_sc = '0;
        end else if (got) begin
            prev_id = eid;
            prev_sc = esc;
        end
        start = 0; abort = 0; rst = 0;
        score1_valid = 0; score2_valid = 0; score1 = '0; score2 = '0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0;
        score1_valid = 0; score2_valid = 0; score1 = '0; score2 = '0;
        mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
        tick();
        tick();
        chk("reset addr", ram_read_addr, 0);
        chk("reset axiiv", filter_axiiv, 0);
        chk("reset axiid", filter_axiid, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset result_id", result_id, 0);
        chk("reset result_score", result_score, 0);
        chk("reset busy", busy, 0);
        rst = 0;
        tick();

        clear();
        sv1[8] = 1; sd1[8] = 5;  sv1[15] = 1; sd1[15] = -2; sv1[22] = 1; sd1[22] = 9;
        sv2[9] = 1; sd2[9] = 7;  sv2[16] = 1; sd2[16] = 8;  sv2[23] = 1; sd2[23] = -1;
        run("t1");
        chk("t2 final score", result_score, 9);
        chk("t2 final id", result_id, 0);

        clear();
        sv1[10] = 1; sd1[10] = -3; sv1[17] = 1; sd1[17] = -5; sv1[24] = 1; sd1[24] = -3;
        sv2[10] = 1; sd2[10] = -7; sv2[17] = 1; sd2[17] = -3; sv2[24] = 1; sd2[24] = -4;
        run("t3");
        chk("t3 tie score", result_score, 32'hFFFF_FFFD);

        clear();
        ab[10] = 1;
        sv1[12] = 1; sd1[12] = 99; sv2[13] = 1; sd2[13] = 99;
        run("t4a");
        clear();
        for (int i = 0; i < CL; i++) mem[i] = 8'($urandom);
        for (int c = 1; c < 35; c++) begin
            sv1[c] = ($urandom_range(0, 3) == 0); sd1[c] = int'($urandom_range(0, 400)) - 200;
            sv2[c] = ($urandom_range(0, 3) == 0); sd2[c] = int'($urandom_range(0, 400)) - 200;
        end
        sv1[30] = 1; sv1[31] = 1; sv1[32] = 1; sv2[30] = 1; sv2[31] = 1; sv2[32] = 1;
        run("t4b");

        clear();
        sv1[6] = 1; sd1[6] = 50; sv1[13] = 1; sd1[13] = 10; sv1[20] = 1; sd1[20] = -4;
        sv1[21] = 1; sd1[21] = 1000;
        sv2[27] = 1; sd2[27] = 40; sv2[28] = 1; sd2[28] = -8; sv2[29] = 1; sd2[29] = 12;
        st[10] = 1; st[25] = 1;
        run("t5");
        chk("t5 extra score ignored", result_score, 50);

        clear();
        sv1[5] = 1; sd1[5] = 1; sv1[6] = 1; sd1[6] = 2; sv1[7] = 1; sd1[7] = 3;
        sv2[8] = 1; sd2[8] = 4;
        rs[24] = 1; st[24] = 1;
        run("t6");

        for (int r = 0; r < 6; r++) begin
            clear();
            for (int i = 0; i < CL; i++) mem[i] = 8'($urandom);
            for (int c = 1; c < 35; c++) begin
                sv1[c] = ($urandom_range(0, 3) == 0); sd1[c] = int'($urandom_range(0, 400)) - 200;
                sv2[c] = ($urandom_range(0, 3) == 0); sd2[c] = int'($urandom_range(0, 400)) - 200;
            end
            sv1[30] = 1; sv1[31] = 1; sv1[32] = 1; sv2[30] = 1; sv2[31] = 1; sv2[32] = 1;
            if (r % 2 == 1) ab[$urandom_range(2, 20)] = 1;
            if (r == 2) st[$urandom_range(2, 20)] = 1;
            run($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
